// File: rtl/pipe_ctl_if.sv
// rtl/pipe_ctl_if.sv - ID instruction, halt request and stage control lines between datapath and pipe_ctl
// Optional statistics outputs appear when PIPE_CTL_STATS_EN is defined.
interface pipe_ctl_if;
  logic [31:0] id_ir;
  logic        halt_req;
  logic        reg_dst;
  logic        alu_src;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        wb_write_enb;
  logic        pc_write;
  logic        id_write;
  logic        ex_bubble;
  logic        stall;
  logic        halted;
  logic        illegal;
`ifdef PIPE_CTL_STATS_EN
  logic [31:0] stall_count;
  logic [31:0] retire_count;

  modport master (
    output id_ir, halt_req,
    input  reg_dst, alu_src, mem_read, mem_write, mem_to_reg, wb_write_enb,
    input  pc_write, id_write, ex_bubble, stall, halted, illegal,
    input  stall_count, retire_count
  );

  modport slave (
    input  id_ir, halt_req,
    output reg_dst, alu_src, mem_read, mem_write, mem_to_reg, wb_write_enb,
    output pc_write, id_write, ex_bubble, stall, halted, illegal,
    output stall_count, retire_count
  );
`else
  modport master (
    output id_ir, halt_req,
    input  reg_dst, alu_src, mem_read, mem_write, mem_to_reg, wb_write_enb,
    input  pc_write, id_write, ex_bubble, stall, halted, illegal
  );

  modport slave (
    input  id_ir, halt_req,
    output reg_dst, alu_src, mem_read, mem_write, mem_to_reg, wb_write_enb,
    output pc_write, id_write, ex_bubble, stall, halted, illegal
  );
`endif
endinterface

// File: rtl/pipe_ctl.sv
// rtl/pipe_ctl.sv - five-stage pipeline control decode, shadow control pipe, RAW hazard stall and halt/drain FSM
// Define PIPE_CTL_STATS_EN to add stall_count / retire_count outputs.
module pipe_ctl #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       clear,
  pipe_ctl_if.slave  bus
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic [4:0] dest;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
  } ctl_t;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_R  = 6'b000000;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_next_cnt;
  ctl_t          r_ex;
  ctl_t          r_mem;
  ctl_t          r_wb;

  ctl_t          w_dec;
  logic          w_use_rs;
  logic          w_use_rt;
  logic          w_reg_dst;
  logic          w_illegal;
  logic          w_hazard;
  logic          w_pc_write;
  logic          w_id_write;
  logic          w_ex_bubble;
  logic          w_stall;
  logic          w_halted;

  logic [5:0]    w_op;
  logic [4:0]    w_rs;
  logic [4:0]    w_rt;
  logic [4:0]    w_rd;
  logic          w_unused;

  assign w_op     = bus.id_ir[31:26];
  assign w_rs     = bus.id_ir[25:21];
  assign w_rt     = bus.id_ir[20:16];
  assign w_rd     = bus.id_ir[15:11];
  assign w_unused = ^bus.id_ir[10:0];

  always_comb begin
    w_dec     = '0;
    w_use_rs  = 1'b0;
    w_use_rt  = 1'b0;
    w_reg_dst = 1'b0;
    w_illegal = 1'b0;
    case (w_op)
      OP_LW: begin
        w_dec.valid    = 1'b1;
        w_dec.regwrite = 1'b1;
        w_dec.dest     = w_rt;
        w_dec.alusrc   = 1'b1;
        w_dec.memread  = 1'b1;
        w_dec.memtoreg = 1'b1;
        w_use_rs       = 1'b1;
      end
      OP_SW: begin
        w_dec.valid    = 1'b1;
        w_dec.alusrc   = 1'b1;
        w_dec.memwrite = 1'b1;
        w_use_rs       = 1'b1;
        w_use_rt       = 1'b1;
      end
      OP_R: begin
        w_dec.valid    = 1'b1;
        w_dec.regwrite = (w_rd != 5'd0);
        w_dec.dest     = w_rd;
        w_reg_dst      = 1'b1;
        w_use_rs       = 1'b1;
        w_use_rt       = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  function automatic logic src_hit(input logic [4:0] src, input logic used, input ctl_t s);
    return used && (src != 5'd0) && s.regwrite && (s.dest == src);
  endfunction

  // WB is not checked: the register file writes on the falling edge, so ID already sees it.
  assign w_hazard = src_hit(w_rs, w_use_rs, r_ex)  | src_hit(w_rt, w_use_rt, r_ex) |
                    src_hit(w_rs, w_use_rs, r_mem) | src_hit(w_rt, w_use_rt, r_mem);

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_ex    <= w_ex_bubble ? ctl_t'('0) : w_dec;
      r_mem   <= r_ex;
      r_wb    <= r_mem;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_pc_write   = 1'b1;
    w_id_write   = 1'b1;
    w_ex_bubble  = 1'b0;
    w_stall      = 1'b0;
    w_halted     = 1'b0;
    case (r_state)
      S_RUN: begin
        w_pc_write  = ~w_hazard;
        w_id_write  = ~w_hazard;
        w_ex_bubble = w_hazard;
        w_stall     = w_hazard;
        if (bus.halt_req && !w_hazard) begin
          w_next_state = S_DRAIN;
          w_next_cnt   = '0;
        end
      end
      S_DRAIN: begin
        w_pc_write  = 1'b0;
        w_id_write  = 1'b0;
        w_ex_bubble = 1'b1;
        w_next_cnt  = r_cnt + CW'(1);
        if (r_cnt == CW'(DRAIN_CYCLES - 1)) begin
          w_next_state = S_HALTED;
          w_next_cnt   = '0;
        end
      end
      S_HALTED: begin
        w_pc_write  = 1'b0;
        w_id_write  = 1'b0;
        w_ex_bubble = 1'b1;
        w_halted    = 1'b1;
        if (!bus.halt_req) begin
          w_next_state = S_RUN;
        end
      end
      default: w_next_state = S_RUN;
    endcase
  end

  assign bus.reg_dst      = w_reg_dst;
  assign bus.illegal      = w_illegal;
  assign bus.alu_src      = r_ex.alusrc;
  assign bus.mem_read     = r_mem.memread;
  assign bus.mem_write    = r_mem.memwrite;
  assign bus.mem_to_reg   = r_wb.memtoreg;
  assign bus.wb_write_enb = r_wb.regwrite;
  assign bus.pc_write     = w_pc_write;
  assign bus.id_write     = w_id_write;
  assign bus.ex_bubble    = w_ex_bubble;
  assign bus.stall        = w_stall;
  assign bus.halted       = w_halted;

`ifdef PIPE_CTL_STATS_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_retire_count;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_stall_count  <= '0;
      r_retire_count <= '0;
    end else begin
      if (w_stall)    r_stall_count  <= r_stall_count + 32'd1;
      if (r_wb.valid) r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign bus.stall_count  = r_stall_count;
  assign bus.retire_count = r_retire_count;
`endif

endmodule

// File: tb/tb_pipe_ctl.sv
// tb/tb_pipe_ctl.sv - directed self-checking bench for pipe_ctl with a small IF/ID fetch model
module tb_pipe_ctl;
  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  pipe_ctl_if bus();

  pipe_ctl #(.DRAIN_CYCLES(3)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] prog [0:7];
  int pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fetch(input int p);
    return (p < 8) ? prog[p] : 32'h0;
  endfunction

  task automatic set_prog(input logic [31:0] a, b, c, d, e);
    for (int i = 0; i < 8; i++) prog[i] = 32'h0;
    prog[0] = a; prog[1] = b; prog[2] = c; prog[3] = d; prog[4] = e;
  endtask

  task automatic do_reset();
    clear        = 1'b1;
    bus.halt_req = 1'b0;
    bus.id_ir    = 32'h0;
    @(posedge clk); #1;
    clear     = 1'b0;
    pc        = 0;
    bus.id_ir = fetch(0);
    #1;
  endtask

  task automatic tick();
    logic adv;
    adv = bus.id_write;
    @(posedge clk); #1;
    if (adv) begin
      pc++;
      bus.id_ir = fetch(pc);
    end
    #1;
  endtask

  initial begin
    // reset state
    set_prog(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    do_reset();
    check_eq("rst_alu_src", bus.alu_src, 0);
    check_eq("rst_mem_read", bus.mem_read, 0);
    check_eq("rst_mem_write", bus.mem_write, 0);
    check_eq("rst_mem_to_reg", bus.mem_to_reg, 0);
    check_eq("rst_wb_write", bus.wb_write_enb, 0);
    check_eq("rst_pc_write", bus.pc_write, 1);
    check_eq("rst_id_write", bus.id_write, 1);
    check_eq("rst_ex_bubble", bus.ex_bubble, 0);
    check_eq("rst_stall", bus.stall, 0);
    check_eq("rst_halted", bus.halted, 0);

    // load-use: lw r1, lw r2, add r3=r1+r2
    set_prog(32'h8C010004, 32'h8C020008, 32'h00221820, 32'h0, 32'h0);
    do_reset();
    check_eq("lu_c0_stall", bus.stall, 0);
    check_eq("lu_c0_reg_dst", bus.reg_dst, 0);
    tick();
    check_eq("lu_c1_stall", bus.stall, 0);
    check_eq("lu_c1_alu_src", bus.alu_src, 1);
    tick();
    check_eq("lu_c2_stall", bus.stall, 1);
    check_eq("lu_c2_pc_write", bus.pc_write, 0);
    check_eq("lu_c2_ex_bubble", bus.ex_bubble, 1);
    check_eq("lu_c2_reg_dst", bus.reg_dst, 1);
    check_eq("lu_c2_mem_read", bus.mem_read, 1);
    tick();
    check_eq("lu_c3_stall", bus.stall, 1);
    check_eq("lu_c3_alu_src", bus.alu_src, 0);
    check_eq("lu_c3_wb_write", bus.wb_write_enb, 1);
    check_eq("lu_c3_mem_to_reg", bus.mem_to_reg, 1);
    tick();
    check_eq("lu_c4_stall", bus.stall, 0);
    check_eq("lu_c4_pc_write", bus.pc_write, 1);
    check_eq("lu_c4_mem_read", bus.mem_read, 0);
    check_eq("lu_c4_wb_write", bus.wb_write_enb, 1);
    tick();
    check_eq("lu_c5_stall", bus.stall, 0);
    check_eq("lu_c5_alu_src", bus.alu_src, 0);
    check_eq("lu_c5_wb_write", bus.wb_write_enb, 0);
`ifdef PIPE_CTL_STATS_EN
    check_eq("lu_stall_count", bus.stall_count, 2);
    check_eq("lu_retire_count", bus.retire_count, 2);
`endif

    // same program with two nops: no stall
    set_prog(32'h8C010004, 32'h8C020008, 32'h0, 32'h0, 32'h00221820);
    do_reset();
    for (int c = 0; c < 6; c++) begin
      check_eq($sformatf("nh_c%0d_stall", c), bus.stall, 0);
      if (c == 3 || c == 4) begin
        check_eq($sformatf("nh_c%0d_wb_write", c), bus.wb_write_enb, 1);
        check_eq($sformatf("nh_c%0d_mem_to_reg", c), bus.mem_to_reg, 1);
      end
      if (c == 5) check_eq("nh_c5_wb_write", bus.wb_write_enb, 0);
      tick();
    end

    // store
    set_prog(32'hAC010008, 32'h0, 32'h0, 32'h0, 32'h0);
    do_reset();
    check_eq("sw_c0_mem_write", bus.mem_write, 0);
    tick();
    check_eq("sw_c1_alu_src", bus.alu_src, 1);
    check_eq("sw_c1_mem_write", bus.mem_write, 0);
    tick();
    check_eq("sw_c2_mem_write", bus.mem_write, 1);
    check_eq("sw_c2_mem_read", bus.mem_read, 0);
    tick();
    check_eq("sw_c3_mem_write", bus.mem_write, 0);
    check_eq("sw_c3_wb_write", bus.wb_write_enb, 0);

    // halt/resume with sub r4 in ID, then a reader of r4
    set_prog(32'h0, 32'h00622022, 32'h00802820, 32'h0, 32'h0);
    do_reset();
    bus.halt_req = 1'b1;
    #1;
    check_eq("hr_c0_pc_write", bus.pc_write, 1);
    tick();
    for (int c = 1; c <= 3; c++) begin
      check_eq($sformatf("hr_c%0d_pc_write", c), bus.pc_write, 0);
      check_eq($sformatf("hr_c%0d_id_write", c), bus.id_write, 0);
      check_eq($sformatf("hr_c%0d_ex_bubble", c), bus.ex_bubble, 1);
      check_eq($sformatf("hr_c%0d_stall", c), bus.stall, 0);
      check_eq($sformatf("hr_c%0d_halted", c), bus.halted, 0);
      tick();
    end
    check_eq("hr_c4_halted", bus.halted, 1);
    check_eq("hr_c4_id_write", bus.id_write, 0);
    check_eq("hr_c4_ex_bubble", bus.ex_bubble, 1);
    bus.halt_req = 1'b0;
    tick();
    check_eq("hr_c5_halted", bus.halted, 0);
    check_eq("hr_c5_pc_write", bus.pc_write, 1);
    check_eq("hr_c5_ex_bubble", bus.ex_bubble, 0);
    check_eq("hr_c5_stall", bus.stall, 0);
    tick();
    check_eq("hr_c6_stall", bus.stall, 1);
    tick();
    check_eq("hr_c7_stall", bus.stall, 1);
    tick();
    check_eq("hr_c8_stall", bus.stall, 0);

    // halt_req dropped during drain still passes through HALTED once
    set_prog(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    do_reset();
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    check_eq("hd_c1_halted", bus.halted, 0);
    tick();
    tick();
    tick();
    check_eq("hd_c4_halted", bus.halted, 1);
    tick();
    check_eq("hd_c5_halted", bus.halted, 0);
    check_eq("hd_c5_pc_write", bus.pc_write, 1);

    // clear mid-drain aborts it
    do_reset();
    bus.halt_req = 1'b1;
    tick();
    tick();
    check_eq("cd_pre_pc_write", bus.pc_write, 0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    #1;
    check_eq("cd_post_pc_write", bus.pc_write, 1);
    check_eq("cd_post_ex_bubble", bus.ex_bubble, 0);
    check_eq("cd_post_halted", bus.halted, 0);
    bus.halt_req = 1'b0;

    // halt_req during a hazard: stall completes first
    set_prog(32'h8C010004, 32'h8C020008, 32'h00221820, 32'h0, 32'h0);
    do_reset();
    tick();
    tick();
    bus.halt_req = 1'b1;
    #1;
    check_eq("hh_c2_stall", bus.stall, 1);
    tick();
    check_eq("hh_c3_stall", bus.stall, 1);
    check_eq("hh_c3_ex_bubble", bus.ex_bubble, 1);
    tick();
    check_eq("hh_c4_pc_write", bus.pc_write, 1);
    check_eq("hh_c4_stall", bus.stall, 0);
    tick();
    check_eq("hh_c5_pc_write", bus.pc_write, 0);
    check_eq("hh_c5_ex_bubble", bus.ex_bubble, 1);
    check_eq("hh_c5_alu_src", bus.alu_src, 0);
    bus.halt_req = 1'b0;

    // illegal opcode, then rd=0 writer followed by a reader of r0
    set_prog(32'hFC000000, 32'h00220020, 32'h00003020, 32'h0, 32'h0);
    do_reset();
    check_eq("il_c0_illegal", bus.illegal, 1);
    check_eq("il_c0_reg_dst", bus.reg_dst, 0);
    tick();
    check_eq("il_c1_illegal", bus.illegal, 0);
    check_eq("il_c1_alu_src", bus.alu_src, 0);
    check_eq("il_c1_stall", bus.stall, 0);
    tick();
    check_eq("il_c2_stall", bus.stall, 0);
    tick();
    check_eq("il_c3_wb_write", bus.wb_write_enb, 0);
    check_eq("il_c3_mem_read", bus.mem_read, 0);
    check_eq("il_c3_stall", bus.stall, 0);
    tick();
    check_eq("il_c4_wb_write", bus.wb_write_enb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
